// File: rtl/ref_count_pkg.sv
// ref_count_pkg: shared mode and direction encodings for the reference modulo counter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ref_count_pkg;

    // Count mode encodings driven on the counter's mode input
    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_UPDN = 2'd2;
    localparam logic [1:0] MODE_HOLD = 2'd3;

    // Direction flag values as seen on the dir output
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/ref_prescaler.sv
// ref_prescaler: divides enabled cycles so the counter advances once every pre_div+1 of them.
// Latency: tick is combinational from the internal phase counter; phase updates on clk5.
// Backpressure: none; the phase counter holds while en5 is low.
// Ports: clk5/reset5 (async, active-high) clock and reset; en5 enable;
//        pre_div division ratio minus one; tick high on the cycle the counter may advance.
// Only compiled when REF_COUNT_PRESCALE_EN is defined.
`ifdef REF_COUNT_PRESCALE_EN
module ref_prescaler #(
    parameter int PW = 8
) (
    input  logic          clk5,
    input  logic          reset5,
    input  logic          en5,
    input  logic [PW-1:0] pre_div,
    output logic          tick
);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // >= rather than == so a runtime decrease of pre_div cannot strand the phase above it
    assign tick = (cnt_q >= pre_div);

    always_comb begin
        cnt_d = cnt_q;
        if (en5) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk5 or posedge reset5) begin
        if (reset5) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/ref_mod_counter.sv
// ref_mod_counter: modulo up/down/triangle counter with shadowed runtime limit and registered compare.
// Latency: tc is combinational (Mealy); q5/dir update on the enabled clk5 edge; cmp_out lags q5 by one cycle.
// Backpressure: none; en5 low freezes count state while the limit shadow and cmp_out keep updating.
// Ports: clk5, reset5 (async, active-high); en5 count enable; mode 0=up 1=down 2=up-down 3=hold;
//        limit_in/limit_wr program the pending limit; cmp_in compare threshold;
//        q5 count, dir direction (1=up), tc terminal-count pulse, cmp_out registered (q5 < cmp_in).
// Optional: define REF_COUNT_PRESCALE_EN to add parameter PW and input pre_div (advance every pre_div+1 enabled cycles).
module ref_mod_counter
    import ref_count_pkg::*;
#(
    parameter int W         = 5,
    parameter int DEF_LIMIT = 20
`ifdef REF_COUNT_PRESCALE_EN
    ,
    parameter int PW        = 8
`endif
) (
    input  logic          clk5,
    input  logic          reset5,
    input  logic          en5,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  limit_in,
    input  logic          limit_wr,
    input  logic [W-1:0]  cmp_in,
`ifdef REF_COUNT_PRESCALE_EN
    input  logic [PW-1:0] pre_div,
`endif
    output logic [W-1:0]  q5,
    output logic          dir,
    output logic          tc,
    output logic          cmp_out
);

    localparam logic [W-1:0] DEF_L = W'(DEF_LIMIT);

    logic [W-1:0] q5_q,   q5_d;
    logic         dir_q,  dir_d;
    logic [W-1:0] lim_q,  lim_d;
    logic [W-1:0] pend_q, pend_d;
    logic         pv_q,   pv_d;
    logic         cmp_q;

    logic         tick;
    logic         adv;
    logic         tc_c;

`ifdef REF_COUNT_PRESCALE_EN
    ref_prescaler #(
        .PW      (PW)
    ) u_prescaler (
        .clk5    (clk5),
        .reset5  (reset5),
        .en5     (en5),
        .pre_div (pre_div),
        .tick    (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // A counting edge: enabled, prescaler ready, and not in hold mode
    assign adv = en5 & tick & (mode != MODE_HOLD);

    // Terminal count against the limit currently in force
    always_comb begin
        tc_c = 1'b0;
        if (adv) begin
            if (lim_q == '0) begin
                tc_c = 1'b1;
            end else begin
                case (mode)
                    MODE_UP:   tc_c = (q5_q == lim_q);
                    MODE_DOWN: tc_c = (q5_q == '0);
                    MODE_UPDN: tc_c = (q5_q == '0) && (dir_q == DIR_DN);
                    default:   tc_c = 1'b0;
                endcase
            end
        end
    end

    // Limit shadow: a write lands in pending, and pending is promoted only at a wrap,
    // so the active limit never changes in the middle of a period.
    always_comb begin
        lim_d  = lim_q;
        pend_d = pend_q;
        pv_d   = pv_q;
        if (tc_c) begin
            if (limit_wr) begin
                lim_d = limit_in;
            end else if (pv_q) begin
                lim_d = pend_q;
            end
            pv_d = 1'b0;
        end else if (limit_wr) begin
            pend_d = limit_in;
            pv_d   = 1'b1;
        end
    end

    // Count next-state. Wrap targets use lim_d so a limit promoted at this wrap
    // is already the bound for the new period.
    always_comb begin
        q5_d  = q5_q;
        dir_d = dir_q;
        if (adv) begin
            if (lim_d == '0) begin
                q5_d = '0;
            end else begin
                case (mode)
                    MODE_UP: begin
                        q5_d  = tc_c ? '0 : q5_q + 1'b1;
                        dir_d = DIR_UP;
                    end
                    MODE_DOWN: begin
                        q5_d  = (q5_q == '0) ? lim_d : q5_q - 1'b1;
                        dir_d = DIR_DN;
                    end
                    MODE_UPDN: begin
                        if (dir_q == DIR_UP) begin
                            if (q5_q >= lim_d) begin
                                q5_d  = lim_d - 1'b1;
                                dir_d = DIR_DN;
                            end else begin
                                q5_d  = q5_q + 1'b1;
                            end
                        end else begin
                            if (q5_q == '0) begin
                                q5_d  = W'(1);
                                dir_d = DIR_UP;
                            end else begin
                                q5_d  = q5_q - 1'b1;
                            end
                        end
                    end
                    default: begin
                        q5_d  = q5_q;
                        dir_d = dir_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk5 or posedge reset5) begin
        if (reset5) begin
            q5_q   <= '0;
            dir_q  <= DIR_UP;
            lim_q  <= DEF_L;
            pend_q <= DEF_L;
            pv_q   <= 1'b0;
            cmp_q  <= 1'b0;
        end else begin
            q5_q   <= q5_d;
            dir_q  <= dir_d;
            lim_q  <= lim_d;
            pend_q <= pend_d;
            pv_q   <= pv_d;
            cmp_q  <= (q5_q < cmp_in);
        end
    end

    assign q5      = q5_q;
    assign dir     = dir_q;
    assign tc      = tc_c;
    assign cmp_out = cmp_q;

endmodule

// File: tb/tb_ref_mod_counter.sv
// tb_ref_mod_counter: scoreboard bench for ref_mod_counter against a behavioural model.
// Latency: expectations are queued at stimulus time and popped by a monitor 2 time units later.
// Backpressure: n/a.
module tb_ref_mod_counter;

    localparam int W = 5;
    localparam int DEF_LIMIT = 20;

    logic         clk5 = 1'b0;
    logic         reset5 = 1'b1;
    logic         en5 = 1'b0;
    logic [1:0]   mode = 2'd3;
    logic [W-1:0] limit_in = '0;
    logic         limit_wr = 1'b0;
    logic [W-1:0] cmp_in = '0;
    logic [W-1:0] q5;
    logic         dir;
    logic         tc;
    logic         cmp_out;
`ifdef REF_COUNT_PRESCALE_EN
    logic [7:0]   pre_div = 8'd0;
`endif

    ref_mod_counter #(
        .W         (W),
        .DEF_LIMIT (DEF_LIMIT)
    ) dut (
        .clk5      (clk5),
        .reset5    (reset5),
        .en5       (en5),
        .mode      (mode),
        .limit_in  (limit_in),
        .limit_wr  (limit_wr),
        .cmp_in    (cmp_in),
`ifdef REF_COUNT_PRESCALE_EN
        .pre_div   (pre_div),
`endif
        .q5        (q5),
        .dir       (dir),
        .tc        (tc),
        .cmp_out   (cmp_out)
    );

    always #5 clk5 = ~clk5;

    typedef struct {
        int q;
        int d;
        int t;
        int c;
        int id;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc_id = 0;

    // Reference model state: count, direction, active/pending limit, compare register
    int m_q, m_dir, m_L, m_P, m_pv, m_cmp;

    task automatic chk(input string nm, input int id, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, id, act, exp_v);
        end
    endtask

    // Monitor: one expectation per stimulus cycle, checked mid-cycle after inputs settle
    always @(negedge clk5) begin
        #2;
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("q5",      e.id, int'(q5),      e.q);
            chk("dir",     e.id, int'(dir),     e.d);
            chk("tc",      e.id, int'(tc),      e.t);
            chk("cmp_out", e.id, int'(cmp_out), e.c);
        end
    end

    task automatic model_reset();
        m_q = 0; m_dir = 1; m_L = DEF_LIMIT; m_P = DEF_LIMIT; m_pv = 0; m_cmp = 0;
    endtask

    // One clock cycle: drive inputs, queue the expected outputs, then step the model
    task automatic step(input int en, input int md, input int lw, input int lin, input int cm, input int rst);
        exp_t e;
        int   tc_e;
        int   new_cmp;
        @(negedge clk5);
        reset5   = (rst != 0);
        en5      = (en != 0);
        mode     = 2'(md);
        limit_wr = (lw != 0);
        limit_in = W'(lin);
        cmp_in   = W'(cm);
        cyc_id++;
        if (rst != 0) begin
            model_reset();
            e = '{q: 0, d: 1, t: 0, c: 0, id: cyc_id};
            sbq.push_back(e);
            return;
        end
        // Terminal count from the rules per mode
        tc_e = 0;
        if (en != 0 && md != 3) begin
            if (m_L == 0)      tc_e = 1;
            else if (md == 0)  tc_e = (m_q == m_L) ? 1 : 0;
            else if (md == 1)  tc_e = (m_q == 0) ? 1 : 0;
            else               tc_e = (m_q == 0 && m_dir == 0) ? 1 : 0;
        end
        e = '{q: m_q, d: m_dir, t: tc_e, c: m_cmp, id: cyc_id};
        sbq.push_back(e);

        new_cmp = (m_q < cm) ? 1 : 0;
        if (tc_e != 0) begin
            if (lw != 0)       m_L = lin;
            else if (m_pv != 0) m_L = m_P;
            m_pv = 0;
        end else if (lw != 0) begin
            m_P = lin;
            m_pv = 1;
        end
        if (en != 0 && md != 3) begin
            if (m_L == 0) begin
                m_q = 0;
            end else if (md == 0) begin
                m_q = (tc_e != 0) ? 0 : m_q + 1;
                m_dir = 1;
            end else if (md == 1) begin
                m_q = (m_q == 0) ? m_L : m_q - 1;
                m_dir = 0;
            end else begin
                // Triangle: bounce off the peak L and the valley 0
                if (m_dir == 1) begin
                    if (m_q >= m_L) begin m_q = m_L - 1; m_dir = 0; end
                    else m_q = m_q + 1;
                end else begin
                    if (m_q == 0) begin m_q = 1; m_dir = 1; end
                    else m_q = m_q - 1;
                end
            end
        end
        m_cmp = new_cmp;
    endtask

    initial begin
        bit first_wr;
        model_reset();

        // Up mode, L=20, 25 cycles: 0..20, 0..3
        step(0, 3, 0, 0, 0, 1);
        for (int i = 0; i < 25; i++) step(1, 0, 0, 0, 0, 0);

        // Down mode from reset, L=5 via write coincident with the first tc
        step(0, 3, 0, 0, 0, 1);
        step(1, 1, 1, 5, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0, 0);

        // Triangle, L=4: reach q=0 dir=up then run 0,1,2,3,4,3,2,1,0,1
        step(0, 3, 0, 0, 0, 1);
        step(1, 1, 1, 4, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 2, 0, 0, 0, 0);

        // Shadowed limit change at q=10, then a write coincident with tc
        step(0, 3, 0, 0, 0, 1);
        first_wr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 10)                                  step(1, 0, 1, 7, 0, 0);
            else if (m_q == 7 && m_L == 7 && first_wr) begin
                first_wr = 1'b0;
                step(1, 0, 1, 3, 0, 0);
            end else                                      step(1, 0, 0, 0, 0, 0);
        end

        // Compare output with cmp_in=3, L=9, plus an en5=0 freeze
        step(0, 3, 0, 0, 0, 1);
        step(1, 1, 1, 9, 3, 0);
        step(1, 0, 0, 0, 3, 0);
        for (int i = 0; i < 22; i++) step(1, 0, 0, 0, 3, 0);
        for (int i = 0; i < 3; i++)  step(0, 0, 0, 0, 3, 0);
        for (int i = 0; i < 6; i++)  step(1, 0, 0, 0, 3, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 12, 0);

        // Async reset at q=13 with a pending limit; the default limit must return
        step(0, 3, 0, 0, 0, 1);
        for (int i = 0; i < 13; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 5, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 24; i++) step(1, 0, 0, 0, 0, 0);

        // L=0 in every mode
        step(0, 3, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, i % 4, 0, 0, 1, 0);

        // Randomised traffic
        step(0, 3, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 8) != 0 ? 1 : 0,
                 int'($urandom % 4),
                 ($urandom % 10) == 0 ? 1 : 0,
                 int'($urandom_range(0, 9)),
                 int'($urandom_range(0, 12)),
                 ($urandom % 120) == 0 ? 1 : 0);
        end

        // Let the monitor drain; a leftover entry means outputs went unchecked
        repeat (3) @(negedge clk5);
        #3;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d queued expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ref_mod_counter.md
Name: ref_mod_counter

Overview:
- Parametrised successor to the fixed 5-bit, 0..20 reference counter.
- Modulo counter with a runtime-programmable terminal value, shadowed so it updates glitch-free.
- Supports up, down and up-down (triangle) count modes.
- Provides a terminal-count pulse and a registered compare output, so it drives PWM/duty comparators directly.

Parameters:
W, 5, counter and limit width in bits (1..16)
DEF_LIMIT, 20, terminal value loaded at reset; must be < 2**W

Ports:
clk5  in  1  system clock, rising edge
reset5  in  1  asynchronous, active-high reset
en5  in  1  count enable; when low, all state holds
mode  in  2  0=up, 1=down, 2=up-down, 3=hold
limit_in  in  W  new terminal value
limit_wr  in  1  one-cycle strobe capturing limit_in into the pending shadow
cmp_in  in  W  compare threshold
q5  out  W  current count
dir  out  1  current direction: 1=up, 0=down
tc  out  1  terminal-count pulse (combinational, Mealy)
cmp_out  out  1  registered (q5 < cmp_in)

Behaviour:
- Interface: reset reset5, asynchronous, active-high; clock clk5.
- Reset values: q5=0, dir=1, active limit=DEF_LIMIT, pending=DEF_LIMIT, pend_valid=0, cmp_out=0.
- State registers are updated only on rising clk5 with en5=1, except the limit shadow and cmp_out, which update every cycle.
- Limit shadow:
  - limit_wr=1 loads pending<=limit_in and sets pend_valid.
  - At a wrap event (tc=1), active limit<=pending and pend_valid clears.
  - limit_wr in the same cycle as tc: limit_in goes directly to active; pend_valid stays 0.
  - Consequence: q5 never exceeds the active limit L.
- Mode 0 (up):
  - Sequence 0,1..L,0. Period L+1.
  - tc = en5 && q5==L.
  - dir=1.
- Mode 1 (down):
  - Sequence L..0,L. Period L+1.
  - tc = en5 && q5==0.
  - dir=0.
  - Out of reset, the first enabled cycle has tc=1 and loads L.
- Mode 2 (up-down):
  - Sequence 0,1..L,L-1..1,0,1... Period 2L.
  - dir flips to 0 at q5==L and to 1 at q5==0.
  - tc = en5 && q5==0 && dir==0, i.e. one pulse per triangle period at the valley. The first valley after reset does not pulse.
- Mode 3: q5 and dir hold; tc=0.
- Mode change mid-count:
  - Takes effect on the next enabled edge from the current q5.
  - Entering mode 0 forces dir=1; entering mode 1 forces dir=0; entering mode 2 keeps the current dir.
- L=0:
  - q5 stays 0 in every mode.
  - tc=1 every enabled cycle in modes 0 and 1, and every enabled cycle in mode 2.
  - dir holds.
- Arithmetic: W-bit unsigned with no overflow (q5 ≤ L < 2**W). Comparisons are unsigned.
- cmp_out: registered every clk5 edge from the current q5 and cmp_in; 1-cycle latency.
  - cmp_in=0 gives constant 0.
  - cmp_in > L gives constant 1 in up mode.
- en5=0: q5, dir and limits hold; tc=0; the limit shadow still captures limit_wr.
- reset5 mid-count: all state returns immediately (asynchronously) to reset values, including any pending limit.

Optional Feature:
- Macro: REF_COUNT_PRESCALE_EN.
- When defined:
  - Adds parameter PW (default 8) and input pre_div [PW-1:0].
  - An internal prescaler makes the counter advance once every pre_div+1 enabled cycles.
  - tc is additionally gated by the prescaler tick.
  - The prescaler resets to 0 on reset5 and holds when en5=0.
  - pre_div=0 is identical to the macro-undefined behaviour.
- When undefined: no prescaler logic or port; the counter advances on every enabled cycle.

Decomposition:
- Package ref_count_pkg holds:
  - MODE_UP=2'd0, MODE_DOWN=2'd1, MODE_UPDN=2'd2, MODE_HOLD=2'd3
  - DIR_UP=1'b1, DIR_DN=1'b0
- Sub-module ref_prescaler: instantiated only under REF_COUNT_PRESCALE_EN; takes clk5, reset5, en5 and pre_div, and outputs a tick.

Test Plan:
- Mode 0, L=20, en5=1 for 25 cycles: q5 steps 0..20 then 0..3; tc high only while q5=20.
- Mode 1, L=5, from reset: tc at q5=0 on the first cycle, then sequence 5,4,3,2,1,0,5; tc high at each q5=0.
- Mode 2, L=4: q5 follows 0,1,2,3,4,3,2,1,0,1; dir drops to 0 after q5=4; tc once at the second q5=0.
- Mode 0, L=20, limit_wr with limit_in=7 at q5=10: count continues to 20, wraps, then runs 0..7; limit_wr coincident with tc applies immediately.
- cmp_in=3, mode 0, L=9: cmp_out high for 3 of every 10 cycles, lagging q5 by 1 cycle; en5=0 freezes q5 and forces tc=0.
- Assert reset5 asynchronously at q5=13 with a pending limit: q5=0, dir=1 and L=DEF_LIMIT immediately; with REF_COUNT_PRESCALE_EN and pre_div=2, q5 advances every 3rd cycle.
